// File: rtl/tetris_soc_key_pio_if.sv
// Avalon-MM register bus between the Nios II fabric and the key PIO.
interface tetris_soc_key_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/tetris_soc_key_pio.sv
// Key input PIO: synchroniser, optional per-bit debounce (KEY_PIO_DEBOUNCE_EN),
// sticky W1C edge capture and a maskable level interrupt.
module tetris_soc_key_pio #(
  parameter int              WIDTH           = 4,
  parameter int              DEBOUNCE_CYCLES = 50000,
  parameter int              EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL    = '1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  tetris_soc_key_pio_if.slave  bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] stable, stable_d;
  logic [WIDTH-1:0] edge_det, edgecap, irqmask;
  logic [31:0]      rd_mux;
  logic             wr;
  logic             unused_bits;

  assign unused_bits = ^{bus.writedata, 32'(DEBOUNCE_CYCLES)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef KEY_PIO_DEBOUNCE_EN
  localparam int              CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   TC = CW'(DEBOUNCE_CYCLES - 1);

  // A bit must disagree with its stable value for DEBOUNCE_CYCLES cycles in a row.
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    logic [CW-1:0] cnt;
    logic          stable_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt      <= '0;
        stable_q <= RESET_LEVEL[i];
      end else if (sync2[i] == stable_q) begin
        cnt <= '0;
      end else if (cnt == TC) begin
        cnt      <= '0;
        stable_q <= sync2[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign stable[i] = stable_q;
  end
`else
  assign stable = sync2;
`endif

  if (EDGE_TYPE == 0) begin : g_rise
    assign edge_det = stable & ~stable_d;
  end else if (EDGE_TYPE == 1) begin : g_fall
    assign edge_det = ~stable & stable_d;
  end else begin : g_any
    assign edge_det = stable ^ stable_d;
  end

  assign wr = bus.chipselect & ~bus.write_n;

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecap;
      default: rd_mux = '0;
    endcase
  end

  // A fresh edge outranks a simultaneous clear so no event is ever lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d     <= RESET_LEVEL;
      irqmask      <= '0;
      edgecap      <= '0;
      bus.readdata <= '0;
    end else begin
      stable_d <= stable;
      if (wr && bus.address == 2'd2)
        irqmask <= bus.writedata[WIDTH-1:0];
      if (wr && bus.address == 2'd3)
        edgecap <= (edgecap & ~bus.writedata[WIDTH-1:0]) | edge_det;
      else
        edgecap <= edgecap | edge_det;
      bus.readdata <= rd_mux;
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_tetris_soc_key_pio.sv
// Directed bench: a falling-edge PIO and an any-edge PIO driven side by side.
module tb_tetris_soc_key_pio;
  localparam int DEB = 8;
`ifdef KEY_PIO_DEBOUNCE_EN
  localparam int LAT = 2 + DEB;
  localparam int MID = 8;
`else
  localparam int LAT = 2;
  localparam int MID = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  in_f, in_a;
  logic        irq_f, irq_a;
  logic [31:0] df, da;
  int          tests = 0;
  int          failures = 0;

  tetris_soc_key_pio_if bus_f ();
  tetris_soc_key_pio_if bus_a ();

  tetris_soc_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(1), .RESET_LEVEL(4'hF))
    u_fall (.clk(clk), .reset_n(reset_n), .bus(bus_f), .in_port(in_f), .irq(irq_f));

  tetris_soc_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(2), .RESET_LEVEL(4'hF))
    u_any (.clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_a), .irq(irq_a));

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_addr(input logic [1:0] a);
    bus_f.address = a;
    bus_a.address = a;
  endtask

  task automatic read(input logic [1:0] a, output logic [31:0] rf, output logic [31:0] ra);
    set_addr(a);
    tick();
    rf = bus_f.readdata;
    ra = bus_a.readdata;
  endtask

  task automatic write(input bit to_any, input logic [1:0] a, input logic [31:0] d);
    set_addr(a);
    bus_f.chipselect = !to_any;
    bus_a.chipselect = to_any;
    bus_f.write_n    = 1'b0;
    bus_a.write_n    = 1'b0;
    bus_f.writedata  = d;
    bus_a.writedata  = d;
    tick();
    bus_f.chipselect = 1'b0;
    bus_a.chipselect = 1'b0;
    bus_f.write_n    = 1'b1;
    bus_a.write_n    = 1'b1;
  endtask

  initial begin
    set_addr(2'd0);
    bus_f.chipselect = 1'b0; bus_a.chipselect = 1'b0;
    bus_f.write_n = 1'b1;    bus_a.write_n = 1'b1;
    bus_f.writedata = '0;    bus_a.writedata = '0;
    in_f = 4'h0;
    in_a = 4'h0;
    tick(3);
    reset_n = 1'b1;
    in_f = 4'hF;
    in_a = 4'hF;

    // reset state
    check("irq_f_reset", {31'd0, irq_f}, 32'd0);
    check("irq_a_reset", {31'd0, irq_a}, 32'd0);
    read(2'd0, df, da);
    check("data_f_reset", df, 32'h0000000F);
    check("data_a_reset", da, 32'h0000000F);
    read(2'd1, df, da);
    check("reserved_read", df, 32'd0);
    read(2'd2, df, da);
    check("mask_reset", df, 32'd0);
    read(2'd3, df, da);
    check("ecap_f_reset", df, 32'd0);
    check("ecap_a_reset", da, 32'd0);

`ifdef KEY_PIO_DEBOUNCE_EN
    in_f[0] = 1'b0;
    tick(5);
    in_f[0] = 1'b1;
    tick(20);
    read(2'd0, df, da);
    check("glitch_data", df, 32'h0000000F);
    read(2'd3, df, da);
    check("glitch_ecap", df, 32'd0);
`endif

    // input-to-DATA latency, falling edge
    set_addr(2'd0);
    tick();
    in_f[0] = 1'b0;
    tick(LAT);
    check("data_before", bus_f.readdata, 32'h0000000F);
    tick();
    check("data_after", bus_f.readdata, 32'h0000000E);
    read(2'd3, df, da);
    check("ecap_fall", df, 32'h1);
    check("ecap_any_quiet", da, 32'h0);

    // interrupt mask
    write(1'b0, 2'd2, 32'h2);
    check("irq_masked", {31'd0, irq_f}, 32'd0);
    write(1'b0, 2'd2, 32'h3);
    check("irq_unmasked", {31'd0, irq_f}, 32'd1);
    read(2'd2, df, da);
    check("mask_read", df, 32'h3);

    // any-edge timing, both directions
    write(1'b1, 2'd2, 32'h8);
    check("irq_any_idle", {31'd0, irq_a}, 32'd0);
    in_a[3] = 1'b0;
    tick(LAT);
    check("irq_any_fall_early", {31'd0, irq_a}, 32'd0);
    tick();
    check("irq_any_fall", {31'd0, irq_a}, 32'd1);
    read(2'd3, df, da);
    check("ecap_any_fall", da, 32'h8);
    write(1'b1, 2'd3, 32'h8);
    check("irq_any_cleared", {31'd0, irq_a}, 32'd0);
    tick(5);
    in_a[3] = 1'b1;
    tick(LAT);
    check("irq_any_rise_early", {31'd0, irq_a}, 32'd0);
    tick();
    check("irq_any_rise", {31'd0, irq_a}, 32'd1);
    read(2'd3, df, da);
    check("ecap_any_rise", da, 32'h8);

    // write-1-to-clear
    in_f[2] = 1'b0;
    tick(LAT + 2);
    read(2'd3, df, da);
    check("ecap_five", df, 32'h5);
    write(1'b0, 2'd2, 32'h4);
    check("irq_bit2", {31'd0, irq_f}, 32'd1);
    write(1'b0, 2'd3, 32'h4);
    check("irq_after_w1c", {31'd0, irq_f}, 32'd0);
    read(2'd3, df, da);
    check("ecap_after_w1c", df, 32'h1);
    write(1'b0, 2'd3, 32'h1);
    read(2'd3, df, da);
    check("ecap_cleared", df, 32'h0);
    in_f[0] = 1'b1;
    tick(LAT + 2);
    read(2'd3, df, da);
    check("rise_ignored", df, 32'h0);
    in_f[0] = 1'b0;
    tick(LAT);
    write(1'b0, 2'd3, 32'h1);
    read(2'd3, df, da);
    check("set_wins", df, 32'h1);

    // reset in the middle of a debounce
    in_f = 4'hF;
    tick(LAT + 3);
    in_f[1] = 1'b0;
    tick(MID);
    reset_n = 1'b0;
    tick(2);
    set_addr(2'd3);
    reset_n = 1'b1;
    tick();
    check("ecap_post_reset", bus_f.readdata, 32'd0);
    check("irq_post_reset", {31'd0, irq_f}, 32'd0);
    set_addr(2'd0);
    tick(LAT - 1);
    check("data_held_reset", bus_f.readdata, 32'h0000000F);
    check("data_any_reset", bus_a.readdata, 32'h0000000F);
    tick();
    check("data_new_debounce", bus_f.readdata, 32'h0000000D);
    set_addr(2'd3);
    tick();
    check("ecap_new_debounce", bus_f.readdata, 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
